// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
//   state_t : FSM state encoding (IDLE, RUN, DONE)
//   NIB_W   : width of one processing slice in bits
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder.
//   master : drives start/a/b/cin/sub, observes busy/done/sum/cout/ovf
//   slave  : the adder side of the same bundle
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// Combinational 4-bit carry-lookahead slice.
//   x, y : operand nibbles
//   ci   : carry into bit 0
//   s    : sum nibble
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (used for signed overflow detection)
module nibble_cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = x & y;
        p = x ^ y;
        // Every carry is expanded directly from g/p/ci rather than chained.
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        s  = p ^ c[3:0];
        co = c[4];
        c3 = c[3];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine, one nibble per clock through
// a single 4-bit CLA slice with the carry registered between nibbles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_if
//           (start/a/b/cin/sub in, busy/done/sum/cout/ovf out)
// Start is accepted in IDLE and DONE; it is ignored while RUN.
// sum/cout/ovf update only on the edge entering DONE.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIB_W-1:0] sl_x;
    logic [NIB_W-1:0] sl_y;
    logic [NIB_W-1:0] sl_s;
    logic             sl_co;
    logic             sl_c3;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        sl_x  = a_q[NIB_W*idx_q +: NIB_W];
        sl_y  = b_q[NIB_W*idx_q +: NIB_W];
        // Result fills from the top: after NIB shifts nibble 0 sits at the LSB.
        res_d = {sl_s, res_q[WIDTH-1:NIB_W]};
    end

    nibble_cla4 u_slice (
        .x  (sl_x),
        .y  (sl_y),
        .ci (c_q),
        .s  (sl_s),
        .co (sl_co),
        .c3 (sl_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        // Subtraction as a + ~b + 1.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        c_q     <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_q <= res_d;
                    c_q   <= sl_co;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= res_d;
                        cout_q  <= sl_co;
                        ovf_q   <= sl_c3 ^ sl_co;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
